// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
//
// Owns the fetch PC, reads instruction memory through a req/ack handshake,
// and buffers fetched bytes in a DEPTH-entry queue presented to decode with a
// valid/ready handshake. A redirect flushes the queue, abandons the in-flight
// fetch's data (not its handshake) and restarts fetch at the target.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   imem_req/imem_addr  memory read request and address (held until ack)
//   imem_ack/imem_data  one-cycle completion pulse with instruction byte
//   inst/inst_pc        queue head instruction and its fetch address
//   inst_valid          queue non-empty
//   inst_ready          decode consumes the head when inst_valid is high
//   redirect            one-cycle flush request, target in redirect_pc
module fetch_unit #(
  parameter int         DEPTH    = 2,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [7:0] inst,
  output logic [7:0] inst_pc,
  output logic       inst_valid,
  input  logic       inst_ready,
  input  logic       redirect,
  input  logic [7:0] redirect_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [7:0]         fetch_pc;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [7:0]         q_inst [DEPTH];
  logic [7:0]         q_pc   [DEPTH];

  logic               outstanding;
  logic               credit;
  logic               issue;
  logic               push;
  logic               pop;

  // Credit counts the in-flight fetch so an ack can never find the queue full.
  always_comb begin
    outstanding = (state != IDLE);
    credit      = ({1'b0, count} + (CNT_W + 1)'(outstanding)) < (CNT_W + 1)'(DEPTH);
    pop         = inst_valid && inst_ready && !redirect;
    next_state  = state;
    issue       = 1'b0;
    push        = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect && credit) begin
          issue      = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          // Data returning after a redirect belongs to the old stream.
          next_state = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          push       = 1'b1;
          next_state = IDLE;
        end
      end
      DROP: begin
        if (imem_ack) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      imem_addr <= RESET_PC;
    end else begin
      if (redirect) begin
        fetch_pc <= redirect_pc;
      end else if (push) begin
        fetch_pc <= fetch_pc + 8'd1;
      end
      if (issue) begin
        imem_addr <= fetch_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage carries no reset; inst_valid gates its meaning.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr] <= imem_data;
      q_pc[wr_ptr]   <= fetch_pc;
    end
  end

  assign imem_req   = (state != IDLE);
  assign inst_valid = (count != '0);
  assign inst       = q_inst[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];

endmodule
